// File: rtl/mem_stage_stack.sv
// mem_stage_stack: pipeline memory stage between EX and WB.
// Combines a DEPTH x DATA_W data memory, a downward-growing hardware stack
// and the write-back select. Executes LOAD/STORE/PUSH/POP and multi-word
// CALL/RET, where the return PC is wider than one data word.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   op_valid, op        operation strobe and opcode (ALU/LOAD/STORE/PUSH/POP/CALL/RET)
//   mem_to_reg, io_sel  write-back source selects
//   addr                LOAD/STORE word address
//   alu_data            ALU result
//   write_data          STORE/PUSH data, IN/OUT pass-through
//   pc                  return PC pushed by CALL
//   stall               combinational; upstream holds inputs while high
//   wb_valid, wb_data   registered write-back result
//   ret_valid, ret_pc   registered one-cycle return PC pulse
//   sp                  stack pointer (next free slot)
//   stack_err           sticky overflow/underflow flag
module mem_stage_stack #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int PC_W        = 32,
  parameter int SP_INIT     = 2**ADDR_W - 1,
  parameter int STACK_LIMIT = 2**ADDR_W - 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic              mem_to_reg,
  input  logic              io_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] write_data,
  input  logic [PC_W-1:0]   pc,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              ret_valid,
  output logic [PC_W-1:0]   ret_pc,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  localparam int DEPTH    = 2**ADDR_W;
  localparam int PC_WORDS = PC_W / DATA_W;
  localparam int CNT_W    = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PC_WORDS - 1);
  localparam logic [ADDR_W-1:0] SP_EMPTY  = ADDR_W'(SP_INIT);
  localparam logic [ADDR_W-1:0] SP_FULL   = ADDR_W'(STACK_LIMIT - 1);

  localparam logic [2:0] OP_ALU   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_PUSH  = 3'b011;
  localparam logic [2:0] OP_POP   = 3'b100;
  localparam logic [2:0] OP_CALL  = 3'b101;
  localparam logic [2:0] OP_RET   = 3'b110;

  typedef enum logic [1:0] {IDLE, CALL_W, RET_W} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   sp_reg, sp_next;
  logic [PC_W-1:0]     hold_reg, hold_next;
  logic                wb_valid_reg, wb_valid_next;
  logic [DATA_W-1:0]   wb_data_reg, wb_data_next;
  logic                ret_valid_reg, ret_valid_next;
  logic [PC_W-1:0]     ret_pc_reg, ret_pc_next;
  logic                stack_err_reg, err_set;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;

  logic [ADDR_W-1:0]   sp_plus1, sp_minus1;
  logic                ovf_hit, unf_hit, last_word;
  logic [CNT_W-1:0]    call_idx;
  logic [DATA_W-1:0]   call_word, alu_path;
  logic [PC_W-1:0]     hold_pop;

  assign sp_plus1  = sp_reg + ADDR_W'(1);
  assign sp_minus1 = sp_reg - ADDR_W'(1);
  assign ovf_hit   = (sp_reg == SP_FULL);
  assign unf_hit   = (sp_reg == SP_EMPTY);
  assign last_word = (cnt_reg == LAST_CNT);
  // CALL emits the most-significant word first; cnt is 0 while in IDLE.
  assign call_idx  = LAST_CNT - cnt_reg;
  assign call_word = pc[call_idx*DATA_W +: DATA_W];
  assign alu_path  = io_sel ? write_data : alu_data;

  // Only LOAD uses the operand address; every pop reads the slot above sp.
  assign rd_addr = (state_reg == IDLE && op == OP_LOAD) ? addr : sp_plus1;
  assign rd_data = mem[rd_addr];

  // RET pops the least-significant word first, so word cnt lands in slice cnt.
  always_comb begin
    hold_pop = hold_reg;
    hold_pop[cnt_reg*DATA_W +: DATA_W] = rd_data;
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    sp_next        = sp_reg;
    hold_next      = hold_reg;
    wb_valid_next  = 1'b0;
    wb_data_next   = wb_data_reg;
    ret_valid_next = 1'b0;
    ret_pc_next    = ret_pc_reg;
    err_set        = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = sp_reg;
    mem_wdata      = write_data;
    stall          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_ALU: begin
              wb_valid_next = 1'b1;
              wb_data_next  = alu_path;
            end
            OP_LOAD: begin
              wb_valid_next = 1'b1;
              wb_data_next  = mem_to_reg ? rd_data : alu_path;
            end
            OP_STORE: begin
              mem_we    = 1'b1;
              mem_waddr = addr;
            end
            OP_PUSH: begin
              if (ovf_hit) begin
                err_set = 1'b1;
              end else begin
                mem_we  = 1'b1;
                sp_next = sp_minus1;
              end
            end
            OP_POP: begin
              wb_valid_next = 1'b1;
              if (unf_hit) begin
                err_set      = 1'b1;
                wb_data_next = '0;
              end else begin
                sp_next      = sp_plus1;
                wb_data_next = mem_to_reg ? rd_data : alu_path;
              end
            end
            OP_CALL: begin
              mem_wdata = call_word;
              if (ovf_hit) begin
                err_set = 1'b1;
              end else begin
                mem_we  = 1'b1;
                sp_next = sp_minus1;
                if (PC_WORDS > 1) begin
                  state_next = CALL_W;
                  cnt_next   = CNT_W'(1);
                  stall      = 1'b1;
                end
              end
            end
            OP_RET: begin
              if (unf_hit) begin
                err_set = 1'b1;
              end else begin
                sp_next   = sp_plus1;
                hold_next = hold_pop;
                if (PC_WORDS > 1) begin
                  state_next = RET_W;
                  cnt_next   = CNT_W'(1);
                  stall      = 1'b1;
                end else begin
                  ret_valid_next = 1'b1;
                  ret_pc_next    = hold_pop;
                end
              end
            end
            default: ;
          endcase
        end
      end

      CALL_W: begin
        mem_wdata = call_word;
        if (ovf_hit) begin
          // Abort: words already pushed stay on the stack.
          err_set    = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          mem_we  = 1'b1;
          sp_next = sp_minus1;
          if (last_word) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
            stall    = 1'b1;
          end
        end
      end

      RET_W: begin
        if (unf_hit) begin
          err_set    = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          sp_next   = sp_plus1;
          hold_next = hold_pop;
          if (last_word) begin
            state_next     = IDLE;
            cnt_next       = '0;
            ret_valid_next = 1'b1;
            ret_pc_next    = hold_pop;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
            stall    = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sp_reg        <= SP_EMPTY;
      hold_reg      <= '0;
      wb_valid_reg  <= 1'b0;
      wb_data_reg   <= '0;
      ret_valid_reg <= 1'b0;
      ret_pc_reg    <= '0;
      stack_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sp_reg        <= sp_next;
      hold_reg      <= hold_next;
      wb_valid_reg  <= wb_valid_next;
      wb_data_reg   <= wb_data_next;
      ret_valid_reg <= ret_valid_next;
      ret_pc_reg    <= ret_pc_next;
      stack_err_reg <= stack_err_reg | err_set;
    end
  end

  // Memory contents survive reset; reset only blocks a write in that cycle.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign wb_valid  = wb_valid_reg;
  assign wb_data   = wb_data_reg;
  assign ret_valid = ret_valid_reg;
  assign ret_pc    = ret_pc_reg;
  assign sp        = sp_reg;
  assign stack_err = stack_err_reg;

endmodule

// File: tb/tb_mem_stage_stack.sv
module tb_mem_stage_stack;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic        mem_to_reg;
  logic        io_sel;
  logic [11:0] addr;
  logic [15:0] alu_data;
  logic [15:0] write_data;
  logic [31:0] pc;
  logic        stall;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        ret_valid;
  logic [31:0] ret_pc;
  logic [11:0] sp;
  logic        stack_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] wb_q[$];
  logic [31:0] ret_q[$];

  localparam logic [2:0] ALU = 3'd0, LOAD = 3'd1, STORE = 3'd2, PUSH = 3'd3,
                         POP = 3'd4, CALL = 3'd5, RET = 3'd6;

  mem_stage_stack #(
    .DATA_W(16), .ADDR_W(12), .PC_W(32), .SP_INIT(4095), .STACK_LIMIT(3840)
  ) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .mem_to_reg(mem_to_reg), .io_sel(io_sel), .addr(addr),
    .alu_data(alu_data), .write_data(write_data), .pc(pc),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .sp(sp), .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %s ok: got 0x%0h", name, act);
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic m2r, input logic io,
                       input logic [11:0] a, input logic [15:0] alu,
                       input logic [15:0] wd, input logic [31:0] p);
    op_valid   = 1'b1;
    op         = o;
    mem_to_reg = m2r;
    io_sel     = io;
    addr       = a;
    alu_data   = alu;
    write_data = wd;
    pc         = p;
  endtask

  task automatic idle_in();
    op_valid = 1'b0;
    op       = ALU;
  endtask

  // Monitor: pops an expectation for every presented result.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          total_cnt++;
          $display("FAIL wb_unexpected: got wb_data 0x%0h, expected no wb_valid", wb_data);
        end else begin
          check("wb_data", 64'(wb_data), 64'(wb_q.pop_front()));
        end
      end
      if (ret_valid) begin
        if (ret_q.size() == 0) begin
          total_cnt++;
          $display("FAIL ret_unexpected: got ret_pc 0x%0h, expected no ret_valid", ret_pc);
        end else begin
          check("ret_pc", 64'(ret_pc), 64'(ret_q.pop_front()));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle_in();
    mem_to_reg = 1'b0; io_sel = 1'b0; addr = '0;
    alu_data = '0; write_data = '0; pc = '0;
    tick(); tick();
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_ret_valid", 64'(ret_valid), 64'd0);
    check("rst_ret_pc", 64'(ret_pc), 64'd0);
    check("rst_sp", 64'(sp), 64'd4095);
    check("rst_stack_err", 64'(stack_err), 64'd0);
    reset = 1'b0;

    // STORE then LOAD
    drive(STORE, 0, 0, 12'h010, 16'h0, 16'hBEEF, 32'h0); tick();
    drive(LOAD, 1, 0, 12'h010, 16'h0, 16'h0, 32'h0); wb_q.push_back(16'hBEEF); tick();

    // ALU path, IN/OUT select
    drive(ALU, 0, 1, 12'h0, 16'hAAAA, 16'h5555, 32'h0); wb_q.push_back(16'h5555); tick();
    drive(ALU, 0, 0, 12'h0, 16'hAAAA, 16'h5555, 32'h0); wb_q.push_back(16'hAAAA); tick();

    // PUSH/PUSH/POP/POP
    drive(PUSH, 0, 0, 12'h0, 16'h0, 16'h1234, 32'h0); tick();
    drive(PUSH, 0, 0, 12'h0, 16'h0, 16'h5678, 32'h0); tick();
    check("sp_after_push", 64'(sp), 64'd4093);
    drive(POP, 1, 0, 12'h0, 16'h0, 16'h0, 32'h0); wb_q.push_back(16'h5678); tick();
    drive(POP, 1, 0, 12'h0, 16'h0, 16'h0, 32'h0); wb_q.push_back(16'h1234); tick();
    check("sp_after_pop", 64'(sp), 64'd4095);

    // CALL: two words, stall on the first only
    drive(CALL, 0, 0, 12'h0, 16'h0, 16'h0, 32'h00012345); #1;
    check("call_stall_w0", 64'(stall), 64'd1);
    tick();
    check("call_stall_w1", 64'(stall), 64'd0);
    check("call_sp_mid", 64'(sp), 64'd4094);
    tick();
    check("call_sp_end", 64'(sp), 64'd4093);
    drive(LOAD, 1, 0, 12'hFFF, 16'h0, 16'h0, 32'h0); wb_q.push_back(16'h0001); tick();
    drive(LOAD, 1, 0, 12'hFFE, 16'h0, 16'h0, 32'h0); wb_q.push_back(16'h2345); tick();

    // RET: two pops, then one ret_valid pulse
    drive(RET, 0, 0, 12'h0, 16'h0, 16'h0, 32'h0); #1;
    ret_q.push_back(32'h00012345);
    check("ret_stall_w0", 64'(stall), 64'd1);
    tick();
    check("ret_stall_w1", 64'(stall), 64'd0);
    tick();
    idle_in();
    check("ret_sp_end", 64'(sp), 64'd4095);
    check("ret_no_err", 64'(stack_err), 64'd0);
    tick(); tick();

    // Underflow
    drive(POP, 1, 0, 12'h0, 16'h0, 16'h0, 32'h0); wb_q.push_back(16'h0000); tick();
    idle_in();
    check("unf_err", 64'(stack_err), 64'd1);
    check("unf_sp", 64'(sp), 64'd4095);
    tick();

    // Clear error, then fill the stack to its limit
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_clears_err", 64'(stack_err), 64'd0);
    for (int i = 0; i < 256; i++) begin
      drive(PUSH, 0, 0, 12'h0, 16'h0, 16'(16'hC000 + i), 32'h0); tick();
    end
    check("full_sp", 64'(sp), 64'd3839);
    check("full_no_err", 64'(stack_err), 64'd0);
    drive(STORE, 0, 0, 12'd3839, 16'h0, 16'h7777, 32'h0); tick();
    drive(PUSH, 0, 0, 12'h0, 16'h0, 16'hDEAD, 32'h0); tick();
    check("ovf_sp", 64'(sp), 64'd3839);
    check("ovf_err", 64'(stack_err), 64'd1);
    drive(LOAD, 1, 0, 12'd3839, 16'h0, 16'h0, 32'h0); wb_q.push_back(16'h7777); tick();
    drive(POP, 1, 0, 12'h0, 16'h0, 16'h0, 32'h0); wb_q.push_back(16'hC0FF); tick();
    check("pop_top_sp", 64'(sp), 64'd3840);

    // CALL overflowing on its second word aborts
    drive(CALL, 0, 0, 12'h0, 16'h0, 16'h0, 32'hABCD1234); #1;
    check("callovf_stall_w0", 64'(stall), 64'd1);
    tick();
    check("callovf_stall_abort", 64'(stall), 64'd0);
    tick();
    idle_in();
    check("callovf_sp", 64'(sp), 64'd3839);
    drive(LOAD, 1, 0, 12'd3840, 16'h0, 16'h0, 32'h0); wb_q.push_back(16'hABCD); tick();
    idle_in(); tick();

    // Reset during CALL_W
    reset = 1'b1; tick(); reset = 1'b0;
    drive(CALL, 0, 0, 12'h0, 16'h0, 16'h0, 32'hCAFEF00D); tick();
    check("midcall_sp", 64'(sp), 64'd4094);
    reset = 1'b1; tick();
    reset = 1'b0; idle_in(); #1;
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_sp", 64'(sp), 64'd4095);
    check("midrst_wb_valid", 64'(wb_valid), 64'd0);
    check("midrst_ret_valid", 64'(ret_valid), 64'd0);
    check("midrst_err", 64'(stack_err), 64'd0);
    tick(); tick(); tick();

    check("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    check("ret_queue_drained", 64'(ret_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
